// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access-mode encodings, FSM states,
// the latched request record and the load-extension helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    mode_e       mode;
    logic        zext;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic zext);
    return zext ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic zext);
    return zext ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: write strobes and replicated store data, load extraction
// with sign/zero extension. Define DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mode_e       mode_i,
  input  logic        zext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
    wstrb_o = '0;
    wword_o = '0;
    rdata_o = '0;
    err_o   = 1'b0;
    case (mode_i)
      MODE_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = extend_byte(rword_i[{addr_lo_i, 3'b000} +: 8], zext_i);
      end
      MODE_HALF: begin
`ifdef DMEM_MISALIGN_CHK_EN
        err_o = addr_lo_i[0];
`else
        err_o = 1'b0;  // addr[0] is simply ignored: access snaps to the half-word
`endif
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = extend_half(addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0], zext_i);
      end
      MODE_WORD: begin
`ifdef DMEM_MISALIGN_CHK_EN
        err_o = |addr_lo_i;
`else
        err_o = 1'b0;
`endif
        wstrb_o = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      default: err_o = 1'b1;
    endcase
    // A faulted access neither writes nor returns data.
    if (err_o) begin
      wstrb_o = '0;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding byte/half/word load or store, response after
// RD_LATENCY cycles. Define DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_mode,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
  localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  state_e                state_q, state_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  req_t                  req_q, req_d;
  logic                  run_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] cur_addr;
  req_t                  cur_req;
  logic [31:0]           cur_word;
  logic [3:0]            al_wstrb;
  logic [31:0]           al_wword;
  logic [31:0]           al_rdata;
  logic                  al_err;

  // run_q keeps req_ready low through reset until the first edge after release.
  assign req_ready = run_q && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // The aligner sees the live request while idle (store path) and the latched one afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr      = req_addr;
      cur_req.we    = req_we;
      cur_req.mode  = mode_e'(req_mode);
      cur_req.zext  = req_unsigned;
      cur_req.wdata = req_wdata;
    end else begin
      cur_addr = addr_q;
      cur_req  = req_q;
    end
  end

  assign cur_word = mem_q[cur_addr[ADDR_WIDTH-1:2]];

  dmem_lane_align u_lane_align (
    .addr_lo_i (cur_addr[1:0]),
    .mode_i    (cur_req.mode),
    .zext_i    (cur_req.zext),
    .wdata_i   (cur_req.wdata),
    .rword_i   (cur_word),
    .wstrb_o   (al_wstrb),
    .wword_o   (al_wword),
    .rdata_o   (al_rdata),
    .err_o     (al_err)
  );

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM and survives clr_n.
  always_ff @(posedge clk) begin
    if (accept && req_we && !al_err) begin
      for (int i = 0; i < 4; i++) begin
        if (al_wstrb[i]) mem_q[req_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= al_wword[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    req_d      = req_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          req_d  = cur_req;
          if (RD_LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = ST_RESP;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      req_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      run_q      <= 1'b1;
    end
  end

  // Only a store can change the array and stores are accepted only in IDLE, so data read
  // from the latched address is stable for the whole RESP phase.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && al_err;
  assign rsp_rdata = (rsp_valid && !req_q.we) ? al_rdata : '0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width; depth = 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from request accept to response; legal range 1..4.
REQ-003 SHALL have parameter INIT_FILE, default "" (empty), hex image loaded into memory at elaboration; empty means all words zero.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  controller can accept a request.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_mode  in  2  00 byte, 01 half-word, 10 word, 11 reserved.
REQ-011 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  out  1  response present.
REQ-014 SHALL have port rsp_ready  in  1  consumer takes response.
REQ-015 SHALL have port rsp_rdata  out  32  load data, right-aligned and extended; zero for stores.
REQ-016 SHALL have port rsp_err  out  1  access faulted (reserved mode or misalignment).

Function
REQ-017 SHALL use FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready; addr, mode, we, unsigned and wdata are latched then.
REQ-019 SHALL commit a store on the accept edge, writing only the addressed lanes: byte -> lane addr[1:0]; half -> lanes [15:0] or [31:16] by addr[1]; word -> all.
REQ-020 SHALL assert rsp_valid exactly RD_LATENCY cycles after the accept edge; with RD_LATENCY = 1, WAIT is skipped.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL deassert req_ready in the cycle rsp_ready is taken; the next accept occurs no earlier than the following cycle (one outstanding access maximum).
REQ-023 SHALL return load data read from the memory array after any same-request store; a load after a store to the same word sees the new value.
REQ-024 SHALL flag req_mode = 11 with rsp_err = 1, perform no write and return rsp_rdata = 0.
REQ-025 SHALL ignore address bits above the array range; address wrap-around is modulo 2**ADDR_WIDTH.

Reset
REQ-026 SHALL on clr_n = 0, at any time and in any state including mid-access, force state to IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and req_ready = 0 until the first edge after release.
REQ-027 SHALL NOT clear memory contents on reset; a store committed before reset persists.

Configuration
REQ-028 SHALL honour macro DMEM_MISALIGN_CHK_EN: when defined, a half-word access with addr[0] = 1 or a word access with addr[1:0] != 00 gives rsp_err = 1, no write and rsp_rdata = 0; when undefined, the low address bits are silently forced to alignment, the access completes normally and rsp_err is asserted only for the reserved mode.

Structure
REQ-029 SHALL take the mode encodings (MODE_BYTE, MODE_HALF, MODE_WORD) and FSM state typedef from shared package dmem_pkg.
REQ-030 SHALL place lane selection, extension and write-strobe generation in a combinational sub-module dmem_lane_align.

Verification
REQ-031 SHALL cover: store word 0x8765_4321 to 0x010, then load byte signed at 0x013 -> rsp_rdata 0xFFFF_FF87, rsp_err 0.
REQ-032 SHALL cover: load half unsigned at 0x012 after REQ-031 store -> 0x0000_8765; signed -> 0xFFFF_8765.
REQ-033 SHALL cover: RD_LATENCY = 3, accept at cycle N -> rsp_valid first high at N+3; rsp_ready held low 5 cycles -> outputs stable and req_ready 0 throughout.
REQ-034 SHALL cover: word load at 0x012 with DMEM_MISALIGN_CHK_EN defined -> rsp_err 1, rdata 0; undefined -> word at 0x010 returned, rsp_err 0.
REQ-035 SHALL cover: mode 11 store to 0x020 -> rsp_err 1, subsequent word load at 0x020 returns the prior value.
REQ-036 SHALL cover: clr_n low during WAIT -> rsp_valid 0 immediately, FSM IDLE after release, memory unchanged.
